// File: rtl/systolic_matmul_if.sv
// rtl/systolic_matmul_if.sv - operand/result handshake bundle for the systolic matrix-multiply engine
interface systolic_matmul_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2*DW + $clog2(N)
);
    logic [N-1:0][N-1:0][DW-1:0] i_a;
    logic [N-1:0][N-1:0][DW-1:0] i_b;
    logic                        i_signed;
    logic                        i_validInput;
    logic                        o_readyInput;
    logic [N-1:0][N-1:0][AW-1:0] o_c;
    logic                        o_validResult;

    modport master (
        output i_a, i_b, i_signed, i_validInput,
        input  o_readyInput, o_c, o_validResult
    );

    modport slave (
        input  i_a, i_b, i_signed, i_validInput,
        output o_readyInput, o_c, o_validResult
    );
endinterface

// File: rtl/systolic_matmul_top.sv
// rtl/systolic_matmul_top.sv - N x N systolic C = A*B engine with skewing feeders and ready/valid accept
module systolic_matmul_top #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    systolic_matmul_if.slave mm
);
    localparam int FS = 2*N - 1;
    localparam int CW = $clog2(3*N);
    localparam logic [CW-1:0] LAST_STEP = CW'(3*N - 3);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          accept;
    logic [CW-1:0] step_q;
    logic          mode_q;

    // Feeders are 2N-1 slots deep so the pre-skewed row/column fits without truncation.
    logic [DW-1:0] row_q [N][FS];
    logic [DW-1:0] col_q [N][FS];
    logic [DW-1:0] a_q   [N][N-1];
    logic [DW-1:0] b_q   [N-1][N];
    logic [AW-1:0] acc_q [N][N];
    logic [DW-1:0] a_in  [N][N];
    logic [DW-1:0] b_in  [N][N];
    logic [AW-1:0] prod  [N][N];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mm.i_validInput) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (step_q == LAST_STEP) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mm.o_readyInput  = (state_q == IDLE);
    assign mm.o_validResult = (state_q == DONE);

    // Operands are widened with their sign bit only in signed mode, so one signed multiply serves both.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = row_q[i][0];
            b_in[0][i] = col_q[i][0];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_q[i][j-1];
                b_in[j][i] = b_q[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = AW'($signed({mode_q & a_in[i][j][DW-1], a_in[i][j]}))
                           * AW'($signed({mode_q & b_in[i][j][DW-1], b_in[i][j]}));
                mm.o_c[i][j] = acc_q[i][j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            mode_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < FS; s++) begin
                    row_q[i][s] <= '0;
                    col_q[i][s] <= '0;
                end
                for (int j = 0; j < N; j++)   acc_q[i][j] <= '0;
                for (int j = 0; j < N-1; j++) a_q[i][j]   <= '0;
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) b_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= mm.i_signed;
                step_q <= '0;
                for (int i = 0; i < N; i++) begin
                    for (int s = 0; s < FS; s++) begin
                        row_q[i][s] <= '0;
                        col_q[i][s] <= '0;
                    end
                    for (int k = 0; k < N; k++) begin
                        row_q[i][k+i] <= mm.i_a[i][k];
                        col_q[i][k+i] <= mm.i_b[k][i];
                    end
                    for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
                end
            end else if (state_q == RUN) begin
                step_q <= step_q + 1'b1;
                for (int i = 0; i < N; i++) begin
                    for (int s = 0; s < FS-1; s++) begin
                        row_q[i][s] <= row_q[i][s+1];
                        col_q[i][s] <= col_q[i][s+1];
                    end
                    row_q[i][FS-1] <= '0;
                    col_q[i][FS-1] <= '0;
                    for (int j = 0; j < N; j++) begin
                        acc_q[i][j] <= acc_q[i][j] + prod[i][j];
                    end
                    for (int j = 0; j < N-1; j++) a_q[i][j] <= a_in[i][j];
                end
                for (int i = 0; i < N-1; i++) begin
                    for (int j = 0; j < N; j++) b_q[i][j] <= b_in[i][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_matmul_top.sv
// tb/tb_systolic_matmul_top.sv - self-checking bench for systolic_matmul_top (N=4/8b directed, N=2 and N=8/4b sweeps)
module tb_systolic_matmul_top;
    typedef int imat_t [16][16];

    typedef struct {
        string      name;
        bit         sgn;
        logic [7:0] av;
        logic [7:0] bv;
        longint     exp;
    } vec_t;

    bit   clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    systolic_matmul_if #(.N(4), .DW(8), .AW(18)) if4 ();
    systolic_matmul_top #(.N(4), .DW(8), .AW(18)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .mm     (if4.slave)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint elem_val(input int raw, input int dw, input bit sgn);
        if (sgn && ((raw >> (dw - 1)) & 1) != 0) return longint'(raw) - (longint'(1) << dw);
        return longint'(raw);
    endfunction

    // Plain dot product of row i of A and column j of B, reduced to aw bits.
    function automatic longint dot(input imat_t a, input imat_t b, input int n, input int i, input int j,
                                   input int dw, input bit sgn, input int aw);
        longint s = 0;
        for (int k = 0; k < n; k++) s += elem_val(a[i][k], dw, sgn) * elem_val(b[k][j], dw, sgn);
        return s & ((longint'(1) << aw) - 1);
    endfunction

    imat_t ma, mb;

    task automatic drive_mats();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                if4.i_a[i][k] = 8'(ma[i][k]);
                if4.i_b[i][k] = 8'(mb[i][k]);
            end
    endtask

    task automatic random_mats();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = int'($urandom_range(0, 255));
                mb[i][k] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                if4.i_a[i][k] = 8'($urandom_range(0, 255));
                if4.i_b[i][k] = 8'($urandom_range(0, 255));
            end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the DONE cycle (or after the budget).
    task automatic run_op(input string tag, input bit sgn);
        int lat;
        int busy;
        drive_mats();
        if4.i_signed     = sgn;
        if4.i_validInput = 1'b1;
        check({tag, "_ready"}, longint'(if4.o_readyInput), 1);
        @(negedge clk);
        if4.i_validInput = 1'b0;
        if4.i_signed     = ~sgn;
        scramble_inputs();
        lat  = 1;
        busy = 0;
        while (!if4.o_validResult && lat < 20) begin
            if (if4.o_readyInput) busy++;
            @(negedge clk);
            lat++;
        end
        if (if4.o_readyInput) busy++;
        check({tag, "_lat"}, longint'(lat), 11);
        check({tag, "_busy"}, longint'(busy), 0);
    endtask

    task automatic check_mat4(input string tag, input imat_t a, input imat_t b, input bit sgn);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), longint'(if4.o_c[i][j]),
                      dot(a, b, 4, i, j, 8, sgn, 18));
    endtask

    function automatic int nonzero_c();
        int n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (if4.o_c[i][j] != '0) n++;
        return n;
    endfunction

    task automatic wait_idle();
        int cnt = 0;
        while (!if4.o_readyInput && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Size sweep: N=2/DW=8 and N=8/DW=4 against the reference model with random operands.
    for (genvar g = 0; g < 2; g++) begin : sweep
        localparam int SN  = (g == 0) ? 2 : 8;
        localparam int SDW = (g == 0) ? 8 : 4;
        localparam int SAW = 2*SDW + $clog2(SN);
        logic  srst_n;
        bit    done_flag = 1'b0;
        imat_t ia, ib;
        bit    sg;
        int    lat;

        systolic_matmul_if #(.N(SN), .DW(SDW), .AW(SAW)) sif ();
        systolic_matmul_top #(.N(SN), .DW(SDW), .AW(SAW)) sdut (
            .i_clk  (clk),
            .i_rst_n(srst_n),
            .mm     (sif.slave)
        );

        initial begin
            srst_n           = 1'b0;
            sif.i_validInput = 1'b0;
            sif.i_signed     = 1'b0;
            sif.i_a          = '0;
            sif.i_b          = '0;
            repeat (3) @(negedge clk);
            srst_n = 1'b1;
            for (int t = 0; t < 6; t++) begin
                sg = t[0];
                for (int i = 0; i < SN; i++)
                    for (int k = 0; k < SN; k++) begin
                        ia[i][k] = (t < 2) ? (1 << SDW) - 1 : int'($urandom_range(0, (1 << SDW) - 1));
                        ib[i][k] = int'($urandom_range(0, (1 << SDW) - 1));
                        sif.i_a[i][k] = SDW'(ia[i][k]);
                        sif.i_b[i][k] = SDW'(ib[i][k]);
                    end
                sif.i_signed     = sg;
                sif.i_validInput = 1'b1;
                @(negedge clk);
                sif.i_validInput = 1'b0;
                lat = 1;
                while (!sif.o_validResult && lat < 3*SN + 6) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("n%0d_lat", SN), longint'(lat), longint'(3*SN - 1));
                for (int i = 0; i < SN; i++)
                    for (int j = 0; j < SN; j++)
                        check($sformatf("n%0d_t%0d_c%0d%0d", SN, t, i, j), longint'(sif.o_c[i][j]),
                              dot(ia, ib, SN, i, j, SDW, sg, SAW));
                @(negedge clk);
            end
            done_flag = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[8];
        imat_t ha[3], hb[3];
        bit    hs[3];
        int    hcyc[3];
        int    n_acc, n_res, spurious, pulses, cnt;

        vecs[0] = '{"u_max",   1'b0, 8'hFF, 8'hFF, 260100};
        vecs[1] = '{"u_zero",  1'b0, 8'h00, 8'h00, 0};
        vecs[2] = '{"s_nn",    1'b1, 8'h80, 8'h80, 65536};
        vecs[3] = '{"s_np",    1'b1, 8'h80, 8'h7F, 197120};
        vecs[4] = '{"u_mix",   1'b0, 8'h80, 8'h7F, 65024};
        vecs[5] = '{"s_m1",    1'b1, 8'hFF, 8'h01, 262140};
        vecs[6] = '{"u_ff1",   1'b0, 8'hFF, 8'h01, 1020};
        vecs[7] = '{"s_pp",    1'b1, 8'h7F, 8'h7F, 64516};

        rst_n            = 1'b0;
        if4.i_validInput = 1'b0;
        if4.i_signed     = 1'b0;
        if4.i_a          = '0;
        if4.i_b          = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", longint'(if4.o_readyInput), 1);
        check("rst_valid", longint'(if4.o_validResult), 0);
        check("rst_c_nonzero", longint'(nonzero_c()), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity times sequence matrix, then hold while idle with garbage inputs.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (i == k) ? 1 : 0;
                mb[i][k] = 4*i + k + 1;
            end
        run_op("ident", 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("ident_c%0d%0d", i, j), longint'(if4.o_c[i][j]), longint'(4*i + j + 1));
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (if4.o_validResult) pulses++;
        end
        check("ident_hold_pulses", longint'(pulses), 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("ident_hold_c%0d%0d", i, j), longint'(if4.o_c[i][j]), longint'(4*i + j + 1));

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin
                    ma[i][k] = int'(vecs[v].av);
                    mb[i][k] = int'(vecs[v].bv);
                end
            run_op(vecs[v].name, vecs[v].sgn);
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    check($sformatf("%s_c%0d%0d", vecs[v].name, i, j), longint'(if4.o_c[i][j]), vecs[v].exp);
            @(negedge clk);
        end

        for (int t = 0; t < 6; t++) begin
            random_mats();
            run_op($sformatf("rnd%0d", t), t[0]);
            check_mat4($sformatf("rnd%0d", t), ma, mb, t[0]);
            @(negedge clk);
        end

        // Valid held high with fresh operands every cycle.
        n_acc    = 0;
        n_res    = 0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            if (if4.o_validResult) begin
                if (n_res < n_acc && n_res < 3) begin
                    check($sformatf("hs%0d_lat", n_res), longint'(c - hcyc[n_res]), 11);
                    check_mat4($sformatf("hs%0d", n_res), ha[n_res], hb[n_res], hs[n_res]);
                    n_res++;
                end else begin
                    spurious++;
                end
            end
            random_mats();
            drive_mats();
            if4.i_signed     = 1'($urandom_range(0, 1));
            if4.i_validInput = 1'b1;
            if (if4.o_readyInput) begin
                if (n_acc < 3) begin
                    ha[n_acc]   = ma;
                    hb[n_acc]   = mb;
                    hs[n_acc]   = if4.i_signed;
                    hcyc[n_acc] = c;
                end
                n_acc++;
            end
            @(negedge clk);
        end
        if4.i_validInput = 1'b0;
        check("hs_accepts", longint'(n_acc), 4);
        check("hs_results", longint'(n_res), 3);
        check("hs_spurious", longint'(spurious), 0);
        check("hs_acc1_cycle", longint'(hcyc[1] - hcyc[0]), 12);
        check("hs_acc2_cycle", longint'(hcyc[2] - hcyc[0]), 24);
        wait_idle();
        check("hs_idle", longint'(if4.o_readyInput), 1);

        // Reset pulse five cycles into an operation.
        random_mats();
        drive_mats();
        if4.i_signed     = 1'b1;
        if4.i_validInput = 1'b1;
        @(negedge clk);
        if4.i_validInput = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_ready", longint'(if4.o_readyInput), 1);
        check("mid_rst_valid", longint'(if4.o_validResult), 0);
        check("mid_rst_c_nonzero", longint'(nonzero_c()), 0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (if4.o_validResult) pulses++;
        end
        check("mid_rst_pulses", longint'(pulses), 0);
        random_mats();
        run_op("post_rst", 1'b0);
        check_mat4("post_rst", ma, mb, 1'b0);
        @(negedge clk);

        cnt = 0;
        while (!(sweep[0].done_flag && sweep[1].done_flag) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("sweep_finished", longint'(sweep[0].done_flag && sweep[1].done_flag), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
